// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP 8-bit core: sequencer state encoding, opcode
// and step widths, the opcode map shared with instruction_decoder, and a helper
// that turns a decoder step count into the index of the last EXEC step.
// -----------------------------------------------------------------------------
package sap_pkg;

   localparam int OPC_W  = 4;
   localparam int STEP_W = 2;

   // Sequencer states; IDLE is encoded as zero so a cleared register is IDLE.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_F_ADDR = 3'd1,
      ST_F_READ = 3'd2,
      ST_F_LOAD = 3'd3,
      ST_EXEC   = 3'd4
   } seq_state_t;

   // Opcode map shared with instruction_decoder.
   localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] OP_MOV   = 4'h1;
   localparam logic [OPC_W-1:0] OP_LDI   = 4'h2;
   localparam logic [OPC_W-1:0] OP_LOAD  = 4'h3;
   localparam logic [OPC_W-1:0] OP_STORE = 4'h4;
   localparam logic [OPC_W-1:0] OP_ADD   = 4'h5;
   localparam logic [OPC_W-1:0] OP_SUB   = 4'h6;
   localparam logic [OPC_W-1:0] OP_AND   = 4'h7;
   localparam logic [OPC_W-1:0] OP_OR    = 4'h8;
   localparam logic [OPC_W-1:0] OP_XOR   = 4'h9;
   localparam logic [OPC_W-1:0] OP_JMP   = 4'hA;
   localparam logic [OPC_W-1:0] OP_JZ    = 4'hB;
   localparam logic [OPC_W-1:0] OP_JNZ   = 4'hC;
   localparam logic [OPC_W-1:0] OP_OUT   = 4'hD;
   localparam logic [OPC_W-1:0] OP_INC   = 4'hE;
   localparam logic [OPC_W-1:0] OP_DEC   = 4'hF;

   // Index of the last EXEC step for a decoder step count. A count of zero is
   // treated as one step so every instruction spends at least one EXEC cycle.
   function automatic logic [STEP_W-1:0] last_step_of(input logic [STEP_W-1:0] req);
      logic [STEP_W-1:0] res;
      if (req == 2'd0) begin
         res = 2'd0;
      end else begin
         res = req - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/retire_counter.sv
// -----------------------------------------------------------------------------
// retire_counter
// Free-running count of retired instructions. Wraps from all-ones to zero.
// Ports:
//   clk      in   clock, rising edge
//   clr_i    in   synchronous clear (highest priority)
//   inc_i    in   increment enable for this cycle
//   count_o  out  CNT_W current count
// -----------------------------------------------------------------------------
module retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment when enabled; natural overflow gives the wrap.
   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Fetch/execute sequencer for the SAP 8-bit core. Runs the three-cycle fetch,
// holds the instruction register and presents opcode/operand, fetch_complete
// and the micro-step index to the instruction decoder. The decoder owns the PC.
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   synchronous active-low reset
//   run              in   execute program; sampled in IDLE and at instruction end
//   mem_data         in   DATA_W RAM read data (valid while in F_LOAD)
//   steps_required   in   2  decoder step count for the current opcode
//   ss_mode          in   1  single-step mode        (SEQ_SINGLE_STEP_EN only)
//   ss_pulse         in   1  single-step advance     (SEQ_SINGLE_STEP_EN only)
//   fetch_pc_to_mar  out  load MAR from PC (F_ADDR)
//   fetch_ram_read   out  RAM read strobe (F_READ)
//   fetch_complete   out  high for every EXEC cycle
//   step             out  2  micro-step index within EXEC, 0-based, never 3
//   opcode           out  4  IR[DATA_W-1:DATA_W-4]
//   operand          out  DATA_W-4 IR[DATA_W-5:0]
//   busy             out  state != IDLE
//   instr_count      out  CNT_W retired instruction count (wraps)
//
// Configuration macro: SEQ_SINGLE_STEP_EN adds ss_mode/ss_pulse. With ss_mode=1
// the machine holds state, step and IR except on cycles with ss_pulse=1.
// -----------------------------------------------------------------------------
module instr_sequencer
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic [DATA_W-1:0]   mem_data,
   input  logic [STEP_W-1:0]   steps_required,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                ss_mode,
   input  logic                ss_pulse,
`endif
   output logic                fetch_pc_to_mar,
   output logic                fetch_ram_read,
   output logic                fetch_complete,
   output logic [STEP_W-1:0]   step,
   output logic [OPC_W-1:0]    opcode,
   output logic [DATA_W-5:0]   operand,
   output logic                busy,
   output logic [CNT_W-1:0]    instr_count
);

   seq_state_t          state_q, state_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [STEP_W-1:0]   last_step_q, last_step_d;

   logic                advance_s;
   logic [STEP_W-1:0]   eff_last_s;
   logic                is_last_s;
   logic                retire_s;

`ifdef SEQ_SINGLE_STEP_EN
   assign advance_s = (~ss_mode) | ss_pulse;
`else
   assign advance_s = 1'b1;
`endif

   // Step 0 takes the live decoder count; later steps use the value latched at
   // step 0 so mid-instruction changes of steps_required have no effect.
   always_comb begin
      eff_last_s = last_step_q;
      if (step_q == 2'd0) begin
         eff_last_s = last_step_of(steps_required);
      end else begin
         eff_last_s = last_step_q;
      end
   end

   assign is_last_s = (state_q == ST_EXEC) && (step_q == eff_last_s);
   assign retire_s  = advance_s && is_last_s;

   // Next-state logic; a held single-step cycle keeps every register unchanged.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      step_d      = step_q;
      last_step_d = last_step_q;
      if (advance_s) begin
         case (state_q)
            ST_IDLE: begin
               if (run) begin
                  state_d = ST_F_ADDR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_F_ADDR: begin
               state_d = ST_F_READ;
            end
            ST_F_READ: begin
               state_d = ST_F_LOAD;
            end
            ST_F_LOAD: begin
               state_d = ST_EXEC;
               ir_d    = mem_data;
               step_d  = 2'd0;
            end
            ST_EXEC: begin
               if (step_q == 2'd0) begin
                  last_step_d = eff_last_s;
               end else begin
                  last_step_d = last_step_q;
               end
               if (is_last_s) begin
                  step_d = 2'd0;
                  if (run) begin
                     state_d = ST_F_ADDR;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  step_d  = step_q + 2'd1;
                  state_d = ST_EXEC;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               step_d      = 2'd0;
               last_step_d = 2'd0;
            end
         endcase
      end else begin
         state_d     = state_q;
         ir_d        = ir_q;
         step_d      = step_q;
         last_step_d = last_step_q;
      end
   end

   // State, IR and step registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= {DATA_W{1'b0}};
         step_q      <= 2'd0;
         last_step_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         step_q      <= step_d;
         last_step_q <= last_step_d;
      end
   end

   // Moore control outputs decoded from the state register only.
   always_comb begin
      fetch_pc_to_mar = 1'b0;
      fetch_ram_read  = 1'b0;
      fetch_complete  = 1'b0;
      busy            = 1'b1;
      case (state_q)
         ST_IDLE:   busy            = 1'b0;
         ST_F_ADDR: fetch_pc_to_mar = 1'b1;
         ST_F_READ: fetch_ram_read  = 1'b1;
         ST_F_LOAD: busy            = 1'b1;
         ST_EXEC:   fetch_complete  = 1'b1;
         default:   busy            = 1'b0;
      endcase
   end

   assign step    = step_q;
   assign opcode  = ir_q[DATA_W-1 -: OPC_W];
   assign operand = ir_q[DATA_W-5:0];

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clk     (clk),
      .clr_i   (~rst_n),
      .inc_i   (retire_s),
      .count_o (instr_count)
   );

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer: reset, NOP, LOAD, JZ with a late change of
// steps_required, run dropped mid-instruction, zero step count, reset during
// EXEC, and (with SEQ_SINGLE_STEP_EN) single-step holding.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [7:0]  mem_data;
   logic [1:0]  steps_required;
`ifdef SEQ_SINGLE_STEP_EN
   logic        ss_mode;
   logic        ss_pulse;
`endif
   logic        fetch_pc_to_mar;
   logic        fetch_ram_read;
   logic        fetch_complete;
   logic [1:0]  step;
   logic [3:0]  opcode;
   logic [3:0]  operand;
   logic        busy;
   logic [15:0] instr_count;

   int total;
   int bad;

   instr_sequencer #(
      .DATA_W (8),
      .CNT_W  (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .run             (run),
      .mem_data        (mem_data),
      .steps_required  (steps_required),
`ifdef SEQ_SINGLE_STEP_EN
      .ss_mode         (ss_mode),
      .ss_pulse        (ss_pulse),
`endif
      .fetch_pc_to_mar (fetch_pc_to_mar),
      .fetch_ram_read  (fetch_ram_read),
      .fetch_complete  (fetch_complete),
      .step            (step),
      .opcode          (opcode),
      .operand         (operand),
      .busy            (busy),
      .instr_count     (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compact check of the control/status outputs: pc2mar, read, complete, busy.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, fetch_pc_to_mar, fetch_ram_read, fetch_complete, busy}, {28'd0, exp});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      run   = 1'b1;
      mem_data = 8'h00;
      steps_required = 2'd1;
`ifdef SEQ_SINGLE_STEP_EN
      ss_mode  = 1'b0;
      ss_pulse = 1'b0;
`endif

      // 1. Reset held two cycles with run=1.
      tick();
      tick();
      check_ctl("rst_ctl", 4'b0000);
      check("rst_step", step, 2'd0);
      check("rst_opcode", opcode, 4'h0);
      check("rst_operand", operand, 4'h0);
      check("rst_count", instr_count, 16'd0);
      rst_n = 1'b1;
      tick();
      check_ctl("rel_faddr", 4'b1001);
      // 2. NOP, one step.
      mem_data = 8'h00;
      steps_required = 2'd1;
      tick();
      check_ctl("rel_fread", 4'b0101);
      tick();
      check_ctl("nop_fload", 4'b0001);
      tick();
      check_ctl("nop_exec", 4'b0011);
      check("nop_step", step, 2'd0);
      check("nop_count0", instr_count, 16'd0);
      tick();
      check_ctl("nop_faddr", 4'b1001);
      check("nop_count1", instr_count, 16'd1);

      // 3. LOAD A (8'h3E), three steps.
      mem_data = 8'h3E;
      steps_required = 2'd3;
      tick();
      tick();
      tick();
      check_ctl("ld_exec0", 4'b0011);
      check("ld_opcode", opcode, 4'h3);
      check("ld_operand", operand, 4'hE);
      check("ld_step0", step, 2'd0);
      tick();
      check("ld_step1", step, 2'd1);
      tick();
      check("ld_step2", step, 2'd2);
      check_ctl("ld_exec2", 4'b0011);
      tick();
      check_ctl("ld_faddr", 4'b1001);
      check("ld_count", instr_count, 16'd2);

      // 4. JZ (8'hB5): two steps, count lowered to 1 during step 1.
      mem_data = 8'hB5;
      steps_required = 2'd2;
      tick();
      tick();
      tick();
      check("jz_step0", step, 2'd0);
      check("jz_opcode", opcode, 4'hB);
      tick();
      steps_required = 2'd1;
      check("jz_step1", step, 2'd1);
      check_ctl("jz_exec1", 4'b0011);
      tick();
      check_ctl("jz_faddr", 4'b1001);
      check("jz_count", instr_count, 16'd3);

      // 5. MOV A (8'h15), run dropped during F_READ.
      mem_data = 8'h15;
      steps_required = 2'd2;
      tick();
      run = 1'b0;
      check_ctl("mov_fread", 4'b0101);
      tick();
      tick();
      check("mov_step0", step, 2'd0);
      tick();
      check("mov_step1", step, 2'd1);
      check_ctl("mov_exec1", 4'b0011);
      tick();
      check_ctl("mov_idle", 4'b0000);
      check("mov_count", instr_count, 16'd4);
      tick();
      check_ctl("mov_idle_hold", 4'b0000);
      run = 1'b1;
      tick();
      check_ctl("mov_rerun", 4'b1001);

      // 6a. steps_required=0 gives a single EXEC cycle.
      mem_data = 8'h2A;
      steps_required = 2'd0;
      tick();
      tick();
      tick();
      check_ctl("z_exec", 4'b0011);
      check("z_operand", operand, 4'hA);
      tick();
      check_ctl("z_faddr", 4'b1001);
      check("z_count", instr_count, 16'd5);

      // 6b. Reset asserted at step 1 of LOAD.
      mem_data = 8'h3E;
      steps_required = 2'd3;
      tick();
      tick();
      tick();
      tick();
      check("lr_step1", step, 2'd1);
      rst_n = 1'b0;
      tick();
      check_ctl("lr_ctl", 4'b0000);
      check("lr_count", instr_count, 16'd0);
      check("lr_opcode", opcode, 4'h0);
      check("lr_step", step, 2'd0);
      run = 1'b0;
      rst_n = 1'b1;
      tick();
      check_ctl("lr_idle", 4'b0000);

`ifdef SEQ_SINGLE_STEP_EN
      // Single step: one transition per pulse, outputs held in between.
      ss_mode = 1'b1;
      run = 1'b1;
      mem_data = 8'h00;
      steps_required = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_ctl("ss_idle_hold", 4'b0000);
      end
      ss_pulse = 1'b1;
      tick();
      ss_pulse = 1'b0;
      check_ctl("ss_faddr", 4'b1001);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_ctl("ss_faddr_hold", 4'b1001);
      end
      ss_pulse = 1'b1;
      tick();
      ss_pulse = 1'b0;
      check_ctl("ss_fread", 4'b0101);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_ctl("ss_fread_hold", 4'b0101);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
